// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: one digit per clock, LSD first, with a
// tens-complement pass to turn a borrowed raw result into a signed magnitude.
module bcd_serial_subtractor #(
  parameter int unsigned NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] diff,
  output logic              neg,
  output logic              err
);

  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_sh, b_sh, r;
  logic            borrow;
  logic [IW-1:0]   idx;

  logic [3:0]      m_dig, s_dig, d_dig;
  logic [4:0]      t;
  logic            b_out;
  logic            last;
  logic            ops_ok;
  logic [W+3:0]    r_ins;

  function automatic logic bcd_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  assign ops_ok = bcd_ok(a) && bcd_ok(b);
  assign last   = (idx == IW'(NDIG - 1));

  // Shared digit cell: SUB uses the shifted operands, COMP computes 0 - r_i.
  always_comb begin
    m_dig = '0;
    s_dig = r[3:0];
    if (state == SUB) begin
      m_dig = a_sh[3:0];
      s_dig = b_sh[3:0];
    end
    t     = {1'b0, m_dig} - {1'b0, s_dig} - {4'b0000, borrow};
    b_out = t[4];
    d_dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    r_ins = {d_dig, r};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ops_ok ? SUB : DONE;
      SUB:     if (last) state_nx = b_out ? COMP : DONE;
      COMP:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r      <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            r      <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            diff   <= '0;
            neg    <= 1'b0;
            err    <= !ops_ok;
          end
        end
        SUB: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          r    <= r_ins[W+3:4];
          idx  <= last ? '0 : idx + IW'(1);
          // Final borrow selects the complement pass; it restarts with no borrow.
          borrow <= last ? 1'b0 : b_out;
          if (last && !b_out) begin
            diff <= r_ins[W+3:4];
            neg  <= 1'b0;
          end
        end
        COMP: begin
          r      <= r_ins[W+3:4];
          idx    <= last ? '0 : idx + IW'(1);
          borrow <= last ? 1'b0 : b_out;
          if (last) begin
            diff <= r_ins[W+3:4];
            neg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomized and directed checks of bcd_serial_subtractor against an
// integer-arithmetic reference of |a-b| and sign.
module tb_bcd_serial_subtractor;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, err;
  logic [W-1:0] diff;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  bcd_serial_subtractor #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit bcd_valid(input logic [W-1:0] v);
    logic [W-1:0] x;
    x = v;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (x[3:0] > 4'd9) return 1'b0;
      x = x >> 4;
    end
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int s;
    int p;
    logic [W-1:0] x;
    s = 0; p = 1; x = v;
    for (int i = 0; i < int'(NDIG); i++) begin
      s += int'(x[3:0]) * p;
      p *= 10;
      x = x >> 4;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v;
    int m;
    v = '0; m = n;
    for (int i = 0; i < int'(NDIG); i++) begin
      v[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after a rising edge; returns likewise.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    bit           e_err, e_neg;
    logic [W-1:0] e_diff;
    int           d, lat, e_lat;
    e_err = !(bcd_valid(av) && bcd_valid(bv));
    d     = bcd2int(av) - bcd2int(bv);
    e_neg = !e_err && (d < 0);
    e_diff = e_err ? '0 : int2bcd(d < 0 ? -d : d);
    // edges after the start-sampling edge until done is visible
    e_lat = e_err ? 0 : (e_neg ? 2 * int'(NDIG) : int'(NDIG));
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 0) chk({tag, "_diffclr"}, 32'(diff), 32'(0));
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_diff"}, 32'(diff), 32'(e_diff));
    chk({tag, "_neg"}, 32'(neg), 32'(e_neg));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    tick();
    chk({tag, "_pulse"}, 32'(done), 32'(0));
    chk({tag, "_idle"}, 32'(busy), 32'(0));
    chk({tag, "_hold"}, 32'({err, neg, diff}), 32'({e_err, e_neg, e_diff}));
  endtask

  initial begin
    int cnt;
    logic [W-1:0] ra, rb;

    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_neg",  32'(neg),  32'(0));
    chk("rst_err",  32'(err),  32'(0));
    rst = 1'b0;
    tick();

    run_op("d4321_1234", 16'h4321, 16'h1234);
    run_op("d1234_4321", 16'h1234, 16'h4321);
    run_op("d1000_0001", 16'h1000, 16'h0001);
    run_op("d0000_0001", 16'h0000, 16'h0001);
    run_op("d5555_5555", 16'h5555, 16'h5555);
    run_op("d12A4_0001", 16'h12A4, 16'h0001);
    run_op("d0000_9999", 16'h0000, 16'h9999);

    // second start while busy must not disturb the running operation
    a = 16'h4321; b = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 16'h0001; b = 16'h9000; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        cnt++;
        chk("busy_ign_diff", 32'(diff), 32'h3087);
        chk("busy_ign_neg", 32'(neg), 32'(0));
      end
      tick();
    end
    chk("busy_ign_ndone", 32'(cnt), 32'(1));

    // start held during the done cycle is not a new request
    a = 16'h0050; b = 16'h0020; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin tick(); cnt++; end
    chk("donecyc_done", 32'(done), 32'(1));
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    tick();
    start = 1'b0;
    chk("donecyc_busy", 32'(busy), 32'(0));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) cnt++;
      tick();
    end
    chk("donecyc_ndone", 32'(cnt), 32'(0));
    chk("donecyc_hold", 32'(diff), 32'h0030);

    // asynchronous reset mid-operation aborts without a done pulse
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_diff", 32'(diff), 32'(0));
    @(posedge clk); #3;
    rst = 1'b0;
    #3;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) cnt++;
      tick();
    end
    chk("abort_ndone", 32'(cnt), 32'(0));
    run_op("post_rst", 16'h9999, 16'h0000);

    for (int i = 0; i < 520; i++) begin
      ra = '0; rb = '0;
      for (int k = 0; k < int'(NDIG); k++) begin
        ra[4*k +: 4] = 4'($urandom_range(9));
        rb[4*k +: 4] = 4'($urandom_range(9));
      end
      if (i % 7 == 0) rb = ra;
      run_op("rand", ra, rb);
    end
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      ra[4*(i % NDIG) +: 4] = 4'($urandom_range(15, 10));
      run_op("rand_bad", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
